// File: rtl/adsr_poly_if.sv
// rtl/adsr_poly_if.sv - amplitude type package and envelope output stream interface
//
// mypackage  : AMPLITUDE_BITS and the amplitude sample type shared with the VCA stage.
// adsr_poly_if ports (master drives, slave receives):
//   out        amplitude          envelope sample of voice out_voice
//   out_voice  [VOICE_BITS-1:0]   voice index that out belongs to
//   out_valid  1                  out/out_voice carry a sample this cycle

package mypackage;
  localparam int AMPLITUDE_BITS = 16;
  typedef logic [AMPLITUDE_BITS-1:0] amplitude;
endpackage

interface adsr_poly_if #(
  parameter int VOICE_BITS = 3
);
  mypackage::amplitude   out;
  logic [VOICE_BITS-1:0] out_voice;
  logic                  out_valid;

  modport master (output out, output out_voice, output out_valid);
  modport slave  (input  out, input  out_voice, input  out_valid);
endinterface

// File: rtl/adsr_poly.sv
// rtl/adsr_poly.sv - time-multiplexed polyphonic ADSR envelope generator
//
// One shared update datapath walks voices 0..NUM_VOICES-1, one voice per clk.
// Optional macro ADSR_HARD_RETRIGGER_EN: a rising gate restarts the attack from level 0
// instead of continuing from the current release level.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   attack_time/decay_time/
//   release_time [TOTAL_BITS]     signed per-update level steps shared by all voices
//   sustain      amplitude        sustain level, full scale = 2**AMPLITUDE_BITS
//   gate         [NUM_VOICES]     per-voice gate, sampled on the voice's service cycle
//   active       [NUM_VOICES]     per-voice envelope not idle
//   bus          adsr_poly_if     indexed output sample stream (master)

module adsr_poly
  import mypackage::*;
#(
  parameter int NUM_VOICES      = 8,
  parameter int TOTAL_BITS      = 48,
  parameter int FRACTIONAL_BITS = 32,
  parameter int VOICE_BITS      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [TOTAL_BITS-1:0] attack_time,
  input  logic signed [TOTAL_BITS-1:0] decay_time,
  input  amplitude                     sustain,
  input  logic signed [TOTAL_BITS-1:0] release_time,
  input  logic [NUM_VOICES-1:0]        gate,
  output logic [NUM_VOICES-1:0]        active,
  adsr_poly_if.master                  bus
);

  // One guard bit so sums and differences never wrap before clamping.
  localparam int W = TOTAL_BITS + 1;
  typedef logic signed [W-1:0] wide_t;
  localparam wide_t ONE = wide_t'(1) <<< FRACTIONAL_BITS;

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} phase_t;

  phase_t                phase_mem [NUM_VOICES];
  logic [TOTAL_BITS-1:0] level_mem [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;
  logic [VOICE_BITS-1:0] vidx;

  phase_t cur_phase, eff_phase, nxt_phase;
  wide_t  cur_level, base, s_level, att_sum, dec_diff, rel_diff, nxt_level;
  logic   g, rise, fall;

  always_comb begin
    cur_phase = phase_mem[vidx];
    cur_level = {1'b0, level_mem[vidx]};
    g         = gate[vidx];
    rise      = g & ~gate_q[vidx];
    fall      = ~g & gate_q[vidx];
    s_level   = wide_t'(sustain) <<< (FRACTIONAL_BITS - AMPLITUDE_BITS);
    eff_phase = cur_phase;
    base      = cur_level;

    // A gate edge selects the phase whose step runs this update; the old
    // phase's own completion is not evaluated.
    if (rise) begin
      eff_phase = ATTACK;
`ifdef ADSR_HARD_RETRIGGER_EN
      base = '0;
`endif
    end else if (fall && (cur_phase == ATTACK || cur_phase == DECAY || cur_phase == SUSTAIN)) begin
      eff_phase = RELEASE;
    end

    att_sum   = base + wide_t'(attack_time);
    dec_diff  = base - wide_t'(decay_time);
    rel_diff  = base - wide_t'(release_time);
    nxt_phase = eff_phase;
    nxt_level = base;

    case (eff_phase)
      IDLE: nxt_level = '0;
      ATTACK: begin
        // Non-positive step means instant attack.
        if (attack_time[TOTAL_BITS-1] || attack_time == '0 || att_sum >= ONE) begin
          nxt_level = ONE;
          nxt_phase = DECAY;
        end else begin
          nxt_level = att_sum;
        end
      end
      DECAY: begin
        if (decay_time[TOTAL_BITS-1] || decay_time == '0 || dec_diff <= s_level) begin
          nxt_level = s_level;
          nxt_phase = SUSTAIN;
        end else begin
          nxt_level = dec_diff;
        end
      end
      SUSTAIN: nxt_level = s_level;
      RELEASE: begin
        if (release_time[TOTAL_BITS-1] || release_time == '0 || rel_diff[W-1] || rel_diff == '0) begin
          nxt_level = '0;
          nxt_phase = IDLE;
        end else begin
          nxt_level = rel_diff;
        end
      end
      default: begin
        nxt_level = '0;
        nxt_phase = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_mem[i] <= IDLE;
        level_mem[i] <= '0;
      end
      gate_q        <= '0;
      vidx          <= '0;
      active        <= '0;
      bus.out       <= '0;
      bus.out_voice <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      phase_mem[vidx] <= nxt_phase;
      level_mem[vidx] <= nxt_level[TOTAL_BITS-1:0];
      gate_q[vidx]    <= g;
      vidx            <= (vidx == VOICE_BITS'(NUM_VOICES - 1)) ? '0 : vidx + 1'b1;
      active[vidx]    <= (nxt_phase != IDLE);
      // Level 1.0 has no bits inside the output window, so saturate it.
      bus.out         <= (nxt_level == ONE) ? '1 : nxt_level[FRACTIONAL_BITS-1 -: AMPLITUDE_BITS];
      bus.out_voice   <= vidx;
      bus.out_valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adsr_poly.sv
// tb/tb_adsr_poly.sv - self-checking bench for adsr_poly against a behavioural envelope model

module tb_adsr_poly;
  localparam int NV = 4;
  localparam longint ONE = 64'sd1 <<< 32;
  localparam logic signed [47:0] STEP = 48'sd42949672;  // 2**32/100
  localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [47:0] attack_time = '0, decay_time = '0, release_time = '0;
  logic [15:0] sustain = '0;
  logic [NV-1:0] gate = '0;
  logic [NV-1:0] active;

  adsr_poly_if #(.VOICE_BITS(2)) bus ();

  adsr_poly #(.NUM_VOICES(NV), .TOTAL_BITS(48), .FRACTIONAL_BITS(32), .VOICE_BITS(2)) dut (
    .clk(clk), .reset(reset), .attack_time(attack_time), .decay_time(decay_time),
    .sustain(sustain), .release_time(release_time), .gate(gate), .active(active), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: per-voice envelope as integers.
  int       m_ph [NV];
  longint   m_lv [NV];
  bit       m_gq [NV];
  int       m_vidx;
  logic [15:0] m_out;
  logic [1:0]  m_voice;
  logic        m_valid;
  logic [NV-1:0] m_active;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_ph[i] = P_IDLE; m_lv[i] = 0; m_gq[i] = 0;
    end
    m_vidx = 0; m_out = '0; m_voice = '0; m_valid = 1'b0; m_active = '0;
  endfunction

  function automatic void model_update();
    int v;
    int ph;
    longint lv, a, d, r, s;
    bit g;
    v  = m_vidx;
    g  = gate[v];
    a  = longint'(attack_time);
    d  = longint'(decay_time);
    r  = longint'(release_time);
    s  = longint'(sustain) * 65536;
    ph = m_ph[v];
    lv = m_lv[v];
    if (g && !m_gq[v]) begin
      ph = P_ATT;
`ifdef ADSR_HARD_RETRIGGER_EN
      lv = 0;
`endif
    end else if (!g && m_gq[v] && (ph == P_ATT || ph == P_DEC || ph == P_SUS)) begin
      ph = P_REL;
    end
    case (ph)
      P_ATT: begin lv = lv + a; if (a <= 0 || lv >= ONE) begin lv = ONE; ph = P_DEC; end end
      P_DEC: begin lv = lv - d; if (d <= 0 || lv <= s) begin lv = s; ph = P_SUS; end end
      P_SUS: lv = s;
      P_REL: begin lv = lv - r; if (r <= 0 || lv <= 0) begin lv = 0; ph = P_IDLE; end end
      default: lv = 0;
    endcase
    m_ph[v] = ph; m_lv[v] = lv; m_gq[v] = g;
    m_out = (lv >= ONE) ? 16'hFFFF : 16'(lv / 65536);
    m_voice = 2'(v);
    m_valid = 1'b1;
    m_active[v] = (ph != P_IDLE);
    m_vidx = (v + 1) % NV;
  endfunction

  // Advance one clock; inputs are stable at the edge, outputs sampled 1 ns after it.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_update();
    #1;
  endtask

  function automatic logic signed [47:0] rand_step();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return -48'sd5;
      2: return 48'sd1 <<< 40;
      default: return 48'($urandom_range(32'd1 << 20, 32'd1 << 28));
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; gate = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.out, bus.out_voice, bus.out_valid, active} !== '0) begin
      errors++;
      $display("FAIL reset_state: out=%h voice=%0d valid=%b active=%b required all 0",
               bus.out, bus.out_voice, bus.out_valid, active);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if ({bus.out, bus.out_voice, bus.out_valid, active} !== {m_out, m_voice, m_valid, m_active}) begin
        errors++;
        $display("FAIL idle_model: out=%h voice=%0d valid=%b active=%b required %h %0d %b %b",
                 bus.out, bus.out_voice, bus.out_valid, active, m_out, m_voice, m_valid, m_active);
      end
      checks++;
      if (bus.out_voice !== 2'(i % NV)) begin
        errors++;
        $display("FAIL idle_voice_seq: got %0d required %0d", bus.out_voice, i % NV);
      end
    end
  endtask

  task automatic test_full_adsr();
    int n2;
    attack_time = STEP; decay_time = STEP; release_time = STEP; sustain = 16'h8000;
    gate[2] = 1'b1;
    n2 = 0;
    for (int i = 0; i < 4 * 225; i++) begin
      if (i == 4 * 170) begin gate[2] = 1'b0; n2 = 0; end
      cycle();
      checks++;
      if ({bus.out, bus.out_voice, bus.out_valid, active} !== {m_out, m_voice, m_valid, m_active}) begin
        errors++;
        $display("FAIL adsr_model: out=%h voice=%0d active=%b required %h %0d %b",
                 bus.out, bus.out_voice, active, m_out, m_voice, m_active);
      end
      if (bus.out_voice != 2'd2) begin
        checks++;
        if (bus.out !== '0) begin
          errors++;
          $display("FAIL adsr_crosstalk: voice %0d out=%h required 0000", bus.out_voice, bus.out);
        end
      end else begin
        n2++;
        if (i < 4 * 170 && n2 == 100) begin
          checks++;
          if (bus.out !== 16'hFFFF) begin
            errors++; $display("FAIL adsr_attack_peak: out=%h required ffff", bus.out);
          end
        end
        if (i < 4 * 170 && n2 == 160) begin
          checks++;
          if (bus.out !== 16'h8000) begin
            errors++; $display("FAIL adsr_sustain: out=%h required 8000", bus.out);
          end
        end
        if (i >= 4 * 170 && n2 == 52) begin
          checks++;
          if (bus.out !== '0 || active[2] !== 1'b0) begin
            errors++;
            $display("FAIL adsr_release_end: out=%h active2=%b required 0000 0", bus.out, active[2]);
          end
        end
      end
    end
  endtask

  task automatic test_independence();
    logic [15:0] q0[$];
    logic [15:0] q3[$];
    gate[0] = 1'b1;
    for (int i = 0; i < 800 + 37 + 300; i++) begin
      if (i == 37)  gate[3] = 1'b1;
      if (i == 800) gate[0] = 1'b0;
      if (i == 837) gate[3] = 1'b0;
      cycle();
      checks++;
      if ({bus.out, bus.out_voice, bus.out_valid, active} !== {m_out, m_voice, m_valid, m_active}) begin
        errors++;
        $display("FAIL indep_model: out=%h voice=%0d active=%b required %h %0d %b",
                 bus.out, bus.out_voice, active, m_out, m_voice, m_active);
      end
      if (bus.out_voice == 2'd0) q0.push_back(bus.out);
      if (bus.out_voice == 2'd3 && i >= 37) q3.push_back(bus.out);
      if (bus.out_voice == 2'd1 || bus.out_voice == 2'd2) begin
        checks++;
        if (bus.out !== '0) begin
          errors++; $display("FAIL indep_crosstalk: voice %0d out=%h required 0000", bus.out_voice, bus.out);
        end
      end
    end
    checks++;
    if (q3.size() < 270) begin
      errors++; $display("FAIL indep_count: voice3 samples=%0d required >= 270", q3.size());
    end
    for (int k = 0; k < q3.size() && k < q0.size(); k++) begin
      checks++;
      if (q0[k] !== q3[k]) begin
        errors++; $display("FAIL indep_match[%0d]: voice3=%h required voice0=%h", k, q3[k], q0[k]);
      end
    end
  endtask

  task automatic test_instant();
    logic [15:0] q[$];
    logic [NV-1:0] act_after[$];
    attack_time = '0; decay_time = '0; release_time = '0; sustain = 16'h4000;
    gate[1] = 1'b1;
    for (int i = 0; i < 12 + 8; i++) begin
      if (i == 12) gate[1] = 1'b0;
      cycle();
      checks++;
      if ({bus.out, bus.out_voice, bus.out_valid, active} !== {m_out, m_voice, m_valid, m_active}) begin
        errors++;
        $display("FAIL instant_model: out=%h voice=%0d active=%b required %h %0d %b",
                 bus.out, bus.out_voice, active, m_out, m_voice, m_active);
      end
      if (bus.out_voice == 2'd1) begin q.push_back(bus.out); act_after.push_back(active); end
    end
    checks++;
    if (q.size() != 5) begin
      errors++; $display("FAIL instant_count: samples=%0d required 5", q.size());
    end else begin
      checks++;
      if (q[0] !== 16'hFFFF) begin errors++; $display("FAIL instant_attack: out=%h required ffff", q[0]); end
      checks++;
      if (q[1] !== 16'h4000) begin errors++; $display("FAIL instant_decay: out=%h required 4000", q[1]); end
      checks++;
      if (q[3] !== 16'h0000 || act_after[3][1] !== 1'b0) begin
        errors++; $display("FAIL instant_release: out=%h active1=%b required 0000 0", q[3], act_after[3][1]);
      end
    end
  endtask

  task automatic test_reattack();
    int first;
    attack_time = STEP; decay_time = STEP; release_time = STEP; sustain = 16'h8000;
    gate[2] = 1'b1;
    first = 0;
    for (int i = 0; i < 4 * 170 + 40 + 4 * 120; i++) begin
      if (i == 4 * 170) gate[2] = 1'b0;
      if (i == 4 * 170 + 40) begin gate[2] = 1'b1; first = 1; end
      if (i == 4 * 170 + 40 + 4 * 60) gate[2] = 1'b0;
      cycle();
      checks++;
      if ({bus.out, bus.out_voice, bus.out_valid, active} !== {m_out, m_voice, m_valid, m_active}) begin
        errors++;
        $display("FAIL reattack_model: out=%h voice=%0d active=%b required %h %0d %b",
                 bus.out, bus.out_voice, active, m_out, m_voice, m_active);
      end
      if (first == 1 && bus.out_voice == 2'd2) begin
        first = 0;
        checks++;
`ifdef ADSR_HARD_RETRIGGER_EN
        if (bus.out >= 16'h0400) begin
          errors++; $display("FAIL reattack_hard: out=%h required below 0400", bus.out);
        end
`else
        if (bus.out < 16'h6000 || bus.out > 16'h7000) begin
          errors++; $display("FAIL reattack_legato: out=%h required 6000..7000", bus.out);
        end
`endif
      end
    end
  endtask

  task automatic test_async_reset();
    attack_time = STEP; decay_time = STEP; release_time = STEP; sustain = 16'h8000;
    gate = 4'b0111;
    for (int i = 0; i < 40; i++) begin
      cycle();
      checks++;
      if ({bus.out, bus.out_voice, bus.out_valid, active} !== {m_out, m_voice, m_valid, m_active}) begin
        errors++;
        $display("FAIL areset_pre_model: out=%h voice=%0d active=%b required %h %0d %b",
                 bus.out, bus.out_voice, active, m_out, m_voice, m_active);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.out, bus.out_voice, bus.out_valid, active} !== '0) begin
      errors++;
      $display("FAIL areset_immediate: out=%h voice=%0d valid=%b active=%b required all 0",
               bus.out, bus.out_voice, bus.out_valid, active);
    end
    gate = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++;
      if ({bus.out, bus.out_voice, bus.out_valid, active} !== {m_out, m_voice, m_valid, m_active}) begin
        errors++;
        $display("FAIL areset_post_model: out=%h voice=%0d active=%b required %h %0d %b",
                 bus.out, bus.out_voice, active, m_out, m_voice, m_active);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        attack_time = rand_step(); decay_time = rand_step(); release_time = rand_step();
        sustain = 16'($urandom);
      end
      if (i % 16 == 0 && $urandom_range(0, 1) == 1) gate[$urandom_range(0, NV - 1)] ^= 1'b1;
      cycle();
      checks++;
      if ({bus.out, bus.out_voice, bus.out_valid, active} !== {m_out, m_voice, m_valid, m_active}) begin
        errors++;
        $display("FAIL random_model: cycle %0d out=%h voice=%0d active=%b required %h %0d %b",
                 i, bus.out, bus.out_voice, active, m_out, m_voice, m_active);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_adsr();
    test_independence();
    test_instant();
    test_reattack();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
